ttc_cmd_decoder: RTL and testbench
==================================

TTC_CMD_DECODER -- requirements
Module: ttc_cmd_decoder

Interface
REQ-001 Parameter MAX_BCID, default 3563: last BCID value before wrap to 0.
REQ-002 Parameter FIFO_DEPTH, default 8: trigger-record FIFO depth, power of 2.
REQ-003 clk  in  1  system clock, 160 MHz; the only clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 valid_in  in  1  upstream decoder word-valid; held until cleared.
REQ-006 data_in  in  16  upstream decoded TTC word.
REQ-007 clr_valid  out  1  one-cycle pulse acknowledging the captured word to upstream.
REQ-008 bc_stb  in  1  one-cycle bunch-crossing strobe in clk domain.
REQ-009 l1a / bcr / ecr  out  1 each  one-cycle command pulses.
REQ-010 brc_stb  out  1; brc_cmd  out  8: other broadcast command pulse and payload.
REQ-011 bcid  out  12  running bunch counter.
REQ-012 evid  out  24  running event counter.
REQ-013 trig_valid  out  1; trig_ready  in  1; trig_data  out  36: trigger record {evid[23:0], bcid[11:0]}.
REQ-014 fifo_ovf  out  1  sticky record-drop flag.
REQ-015 err_cnt  out  8  saturating bad-word counter.

Function
REQ-016 Word format SHALL be: [15:14] type (00 idle, 01 L1A, 10 broadcast, 11 reserved); [13:8] ignored; [7:0] payload.
REQ-017 Handshake FSM states SHALL be IDLE and ACK.
REQ-018 IDLE with valid_in=1: latch data_in, go to ACK; clr_valid=1 during the ACK cycle.
REQ-019 ACK: valid_in ignored (stale word); always return to IDLE next cycle; throughput max 1 word per 2 cycles.
REQ-020 Decode SHALL act in the cycle after capture (in ACK); command pulses last exactly one cycle.
REQ-021 Type 00: no action.
REQ-022 Type 01: l1a pulse; push {evid, bcid} sampled before increment; evid+1, wrapping at 2^24.
REQ-023 Type 10: payload[0] -> bcr pulse, bcid:=0; payload[1] -> ecr pulse, evid:=0; both bits set -> both act.
REQ-024 Type 10 with payload[7:2] nonzero SHALL also pulse brc_stb with brc_cmd = payload.
REQ-025 Type 11: err_cnt+1, saturating at 255; no other action.
REQ-026 bc_stb: bcid+1; bcid==MAX_BCID -> 0.
REQ-027 BCR coincident with bc_stb: bcid=0; BCR wins.
REQ-028 L1A record captures bcid as registered before any same-cycle bc_stb update.
REQ-029 FIFO pop on trig_valid & trig_ready; trig_data valid while trig_valid=1; first-word-fall-through.
REQ-030 FIFO full and push without pop: record dropped, fifo_ovf:=1; evid still increments.
REQ-031 FIFO full and push with pop in the same cycle: both accepted; no overflow.
REQ-032 Empty FIFO: trig_valid=0; trig_ready ignored.

Reset
REQ-033 rst SHALL set the FSM to IDLE, all pulses 0, bcid=0, evid=0, err_cnt=0, fifo_ovf=0, FIFO empty, trig_valid=0.
REQ-034 rst mid-handshake: clr_valid=0 next cycle; latched word discarded.
REQ-035 fifo_ovf SHALL clear only on rst; ECR SHALL NOT clear it.

Structure
REQ-036 Package ttc_pkg SHALL hold the type codes, BCR/ECR bit indices, and counter and record widths.
REQ-037 Sub-module ttc_trig_fifo SHALL be a synchronous FIFO (FIFO_DEPTH x 36) with full/empty flags.

Verification
REQ-038 valid_in held high with data_in=16'h4000 -> clr_valid one cycle, l1a one pulse, record {0, bcid}, evid=1.
REQ-039 bc_stb repeated 3564 times from 0 -> bcid reaches 3563, then 0; word 16'h8001 coincident with bc_stb -> bcid=0.
REQ-040 Word 16'h8003 after 5 L1As -> bcr and ecr pulse together; evid=0, bcid=0; next L1A record evid=0.
REQ-041 9 L1As with trig_ready=0 -> 8 records held, fifo_ovf=1, evid=9; drain returns evid 0..7 in order.
REQ-042 300 words of 16'hC000 -> err_cnt=255; 16'h8084 -> brc_stb with brc_cmd=8'h84, no bcr/ecr.
REQ-043 rst asserted during ACK -> clr_valid low next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC command decoder: word type codes,
// broadcast bit positions, counter/record widths and the handshake states.
package ttc_pkg;

  localparam int WORD_W    = 16;
  localparam int PAYLOAD_W = 8;
  localparam int BCID_W    = 12;
  localparam int EVID_W    = 24;
  localparam int ERR_W     = 8;
  localparam int REC_W     = EVID_W + BCID_W;

  // Bit positions inside the broadcast payload
  localparam int BCR_BIT = 0;
  localparam int ECR_BIT = 1;

  typedef enum logic [1:0] {
    TYPE_IDLE = 2'b00,
    TYPE_L1A  = 2'b01,
    TYPE_BRC  = 2'b10,
    TYPE_RSV  = 2'b11
  } word_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } hs_state_e;

  // Extract the type field from a decoded TTC word
  function automatic word_type_e word_type(input logic [WORD_W-1:0] w);
    return word_type_e'(w[WORD_W-1:WORD_W-2]);
  endfunction

endpackage

// File: rtl/ttc_cmd_decoder_if.sv
// Upstream word handshake and downstream trigger-record stream.
// master = environment side, slave = decoder side.
interface ttc_cmd_decoder_if;
  import ttc_pkg::*;

  logic                valid_in;
  logic [WORD_W-1:0]   data_in;
  logic                clr_valid;
  logic                trig_valid;
  logic                trig_ready;
  logic [REC_W-1:0]    trig_data;

  modport master (
    output valid_in, data_in, trig_ready,
    input  clr_valid, trig_valid, trig_data
  );

  modport slave (
    input  valid_in, data_in, trig_ready,
    output clr_valid, trig_valid, trig_data
  );

endinterface

// File: rtl/ttc_trig_fifo.sv
// Synchronous first-word-fall-through FIFO holding trigger records.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ttc_trig_fifo
  import ttc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = REC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o    = (count_q == {(AW+1){1'b0}});
  assign full_o     = (count_q == FULL_CNT);
  assign do_pop_s   = pop_i & ~empty_o;
  assign do_push_s  = push_i & (~full_o | do_pop_s);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Record storage; contents are qualified by the count, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ttc_cmd_decoder.sv
// TTC command decoder: two-state capture/acknowledge handshake with the
// upstream word decoder, command pulse generation, BCID/EVID counters,
// reserved-word error counter and an L1A trigger-record FIFO.
module ttc_cmd_decoder
  import ttc_pkg::*;
#(
  parameter int MAX_BCID   = 3563,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ttc_cmd_decoder_if.slave     bus,
  input  logic                 bc_stb,
  output logic                 l1a,
  output logic                 bcr,
  output logic                 ecr,
  output logic                 brc_stb,
  output logic [PAYLOAD_W-1:0] brc_cmd,
  output logic [BCID_W-1:0]    bcid,
  output logic [EVID_W-1:0]    evid,
  output logic                 fifo_ovf,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam logic [BCID_W-1:0] BCID_LAST = BCID_W'(MAX_BCID);

  hs_state_e            state_q;
  logic                 clr_valid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 l1a_q, bcr_q, ecr_q, brc_stb_q;
  logic [BCID_W-1:0]    bcid_q, bcid_d;
  logic [EVID_W-1:0]    evid_q, evid_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 ovf_q, ovf_d;

  logic capture_s;
  logic is_l1a_s, is_bcr_s, is_ecr_s, is_brc_s, is_err_s;
  logic fifo_full_s, fifo_empty_s, fifo_pop_s, drop_s;

  // A word is taken only in IDLE; in ACK the still-asserted valid is stale
  assign capture_s = (state_q == ST_IDLE) & bus.valid_in;

  // Classify the word being captured this cycle
  always_comb begin
    is_l1a_s = 1'b0;
    is_bcr_s = 1'b0;
    is_ecr_s = 1'b0;
    is_brc_s = 1'b0;
    is_err_s = 1'b0;
    if (capture_s) begin
      case (word_type(bus.data_in))
        TYPE_L1A: is_l1a_s = 1'b1;
        TYPE_BRC: begin
          is_bcr_s = bus.data_in[BCR_BIT];
          is_ecr_s = bus.data_in[ECR_BIT];
          is_brc_s = |bus.data_in[PAYLOAD_W-1:2];
        end
        TYPE_RSV:  is_err_s = 1'b1;
        TYPE_IDLE: is_err_s = 1'b0;
        default:   is_err_s = 1'b0;
      endcase
    end else begin
      is_err_s = 1'b0;
    end
  end

  // A full FIFO only loses the record when nothing leaves in the same cycle
  assign fifo_pop_s = bus.trig_ready & ~fifo_empty_s;
  assign drop_s     = is_l1a_s & fifo_full_s & ~fifo_pop_s;

  // Next values of the counters and the sticky overflow flag
  always_comb begin
    bcid_d = bcid_q;
    evid_d = evid_q;
    err_d  = err_q;
    ovf_d  = ovf_q | drop_s;
    // BCR has priority over a coincident bunch-crossing strobe
    if (is_bcr_s) begin
      bcid_d = {BCID_W{1'b0}};
    end else if (bc_stb) begin
      bcid_d = (bcid_q == BCID_LAST) ? {BCID_W{1'b0}} : bcid_q + BCID_W'(1);
    end else begin
      bcid_d = bcid_q;
    end
    if (is_ecr_s) begin
      evid_d = {EVID_W{1'b0}};
    end else if (is_l1a_s) begin
      evid_d = evid_q + EVID_W'(1);
    end else begin
      evid_d = evid_q;
    end
    if (is_err_s && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // Handshake FSM with registered pulses and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_valid_q <= 1'b0;
      payload_q   <= {PAYLOAD_W{1'b0}};
      l1a_q       <= 1'b0;
      bcr_q       <= 1'b0;
      ecr_q       <= 1'b0;
      brc_stb_q   <= 1'b0;
      bcid_q      <= {BCID_W{1'b0}};
      evid_q      <= {EVID_W{1'b0}};
      err_q       <= {ERR_W{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.valid_in) begin
            state_q     <= ST_ACK;
            clr_valid_q <= 1'b1;
            payload_q   <= bus.data_in[PAYLOAD_W-1:0];
          end else begin
            state_q     <= ST_IDLE;
            clr_valid_q <= 1'b0;
          end
        end
        ST_ACK: begin
          state_q     <= ST_IDLE;
          clr_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          clr_valid_q <= 1'b0;
        end
      endcase
      l1a_q     <= is_l1a_s;
      bcr_q     <= is_bcr_s;
      ecr_q     <= is_ecr_s;
      brc_stb_q <= is_brc_s;
      bcid_q    <= bcid_d;
      evid_q    <= evid_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  // Record holds the counters as registered before this cycle's updates
  ttc_trig_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (is_l1a_s),
    .push_data_i ({evid_q, bcid_q}),
    .pop_i       (fifo_pop_s),
    .pop_data_o  (bus.trig_data),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign bus.clr_valid  = clr_valid_q;
  assign bus.trig_valid = ~fifo_empty_s;
  assign l1a            = l1a_q;
  assign bcr            = bcr_q;
  assign ecr            = ecr_q;
  assign brc_stb        = brc_stb_q;
  assign brc_cmd        = payload_q;
  assign bcid           = bcid_q;
  assign evid           = evid_q;
  assign err_cnt        = err_q;
  assign fifo_ovf       = ovf_q;

endmodule

// File: tb/tb_ttc_cmd_decoder.sv
// Directed self-checking bench for ttc_cmd_decoder.
module tb_ttc_cmd_decoder;

  logic        clk;
  logic        rst;
  logic        bc_stb;
  logic        l1a, bcr, ecr, brc_stb;
  logic [7:0]  brc_cmd;
  logic [11:0] bcid;
  logic [23:0] evid;
  logic        fifo_ovf;
  logic [7:0]  err_cnt;
  int          total;
  int          bad;

  ttc_cmd_decoder_if bus_if ();

  ttc_cmd_decoder #(
    .MAX_BCID   (3563),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .bc_stb   (bc_stb),
    .l1a      (l1a),
    .bcr      (bcr),
    .ecr      (ecr),
    .brc_stb  (brc_stb),
    .brc_cmd  (brc_cmd),
    .bcid     (bcid),
    .evid     (evid),
    .fifo_ovf (fifo_ovf),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle past the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Present a word for its capture edge, then withdraw valid (DUT is in ACK)
  task automatic put_word(input logic [15:0] w);
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = w;
    tick();
    bus_if.valid_in = 1'b0;
  endtask

  // Full two-cycle word transfer
  task automatic send(input logic [15:0] w);
    put_word(w);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bc_stb = 1'b0;
    bus_if.valid_in = 1'b0;
    bus_if.data_in = 16'h0000;
    bus_if.trig_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_clr", bus_if.clr_valid, 1'b0);
    chk("rst_l1a", l1a, 1'b0);
    chk("rst_bcid", bcid, 12'd0);
    chk("rst_evid", evid, 24'd0);
    chk("rst_err", err_cnt, 8'd0);
    chk("rst_ovf", fifo_ovf, 1'b0);
    chk("rst_tvalid", bus_if.trig_valid, 1'b0);

    // L1A with valid held through ACK: one capture only
    bus_if.valid_in = 1'b1;
    bus_if.data_in  = 16'h4000;
    tick();
    chk("l1a_clr", bus_if.clr_valid, 1'b1);
    chk("l1a_pulse", l1a, 1'b1);
    chk("l1a_evid", evid, 24'd1);
    chk("l1a_tvalid", bus_if.trig_valid, 1'b1);
    chk("l1a_rec", bus_if.trig_data, 36'h0_0000_0000);
    tick();
    bus_if.valid_in = 1'b0;
    chk("l1a_clr_off", bus_if.clr_valid, 1'b0);
    chk("l1a_pulse_off", l1a, 1'b0);
    chk("l1a_evid_once", evid, 24'd1);
    bus_if.trig_ready = 1'b1;
    tick();
    bus_if.trig_ready = 1'b0;
    chk("l1a_drained", bus_if.trig_valid, 1'b0);

    // BCID wrap
    bc_stb = 1'b1;
    for (int i = 0; i < 3563; i++) tick();
    chk("bcid_max", bcid, 12'd3563);
    tick();
    chk("bcid_wrap", bcid, 12'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("bcid_10", bcid, 12'd10);
    // BCR coincident with bc_stb wins
    put_word(16'h8001);
    bc_stb = 1'b0;
    chk("bcr_pulse", bcr, 1'b1);
    chk("bcr_no_ecr", ecr, 1'b0);
    chk("bcr_no_brc", brc_stb, 1'b0);
    chk("bcr_bcid", bcid, 12'd0);
    tick();
    chk("bcr_pulse_off", bcr, 1'b0);

    // BCR+ECR after five L1As
    bus_if.trig_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'h4000);
    chk("evid_6", evid, 24'd6);
    bc_stb = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bc_stb = 1'b0;
    chk("bcid_7", bcid, 12'd7);
    put_word(16'h8003);
    chk("both_bcr", bcr, 1'b1);
    chk("both_ecr", ecr, 1'b1);
    chk("both_evid", evid, 24'd0);
    chk("both_bcid", bcid, 12'd0);
    tick();
    bus_if.trig_ready = 1'b0;
    chk("both_empty", bus_if.trig_valid, 1'b0);
    bc_stb = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bc_stb = 1'b0;
    put_word(16'h4000);
    chk("post_ecr_rec", bus_if.trig_data, 36'h0_0000_0003);
    chk("post_ecr_evid", evid, 24'd1);
    tick();
    bus_if.trig_ready = 1'b1;
    tick();
    bus_if.trig_ready = 1'b0;

    // Push into full FIFO with simultaneous pop is accepted
    send(16'h8002);
    chk("ecr_evid0", evid, 24'd0);
    for (int i = 0; i < 8; i++) send(16'h4000);
    chk("full_tvalid", bus_if.trig_valid, 1'b1);
    bus_if.trig_ready = 1'b1;
    put_word(16'h4000);
    bus_if.trig_ready = 1'b0;
    chk("pushpop_evid", evid, 24'd9);
    chk("pushpop_ovf", fifo_ovf, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain_v%0d", i), bus_if.trig_valid, 1'b1);
      chk($sformatf("pp_drain_e%0d", i), bus_if.trig_data[35:12], 24'(i + 1));
      bus_if.trig_ready = 1'b1;
      tick();
      bus_if.trig_ready = 1'b0;
    end
    chk("pp_empty", bus_if.trig_valid, 1'b0);

    // Overflow: nine L1As without draining
    send(16'h8002);
    for (int i = 0; i < 8; i++) send(16'h4000);
    chk("ovf_8", fifo_ovf, 1'b0);
    send(16'h4000);
    chk("ovf_9", fifo_ovf, 1'b1);
    chk("ovf_evid", evid, 24'd9);
    send(16'h8002);
    chk("ovf_sticky_ecr", fifo_ovf, 1'b1);
    chk("ovf_ecr_evid", evid, 24'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain_v%0d", i), bus_if.trig_valid, 1'b1);
      chk($sformatf("ovf_drain_e%0d", i), bus_if.trig_data[35:12], 24'(i));
      bus_if.trig_ready = 1'b1;
      tick();
      bus_if.trig_ready = 1'b0;
    end
    chk("ovf_empty", bus_if.trig_valid, 1'b0);

    // Idle word: acknowledged, no action
    put_word(16'h0000);
    chk("idle_clr", bus_if.clr_valid, 1'b1);
    chk("idle_l1a", l1a, 1'b0);
    chk("idle_brc", brc_stb, 1'b0);
    tick();

    // Reserved words saturate the error counter
    put_word(16'hC000);
    chk("err_1", err_cnt, 8'd1);
    chk("err_no_l1a", l1a, 1'b0);
    tick();
    for (int i = 0; i < 299; i++) send(16'hC000);
    chk("err_sat", err_cnt, 8'd255);

    // Other broadcast command
    put_word(16'h8084);
    chk("brc_stb", brc_stb, 1'b1);
    chk("brc_cmd", brc_cmd, 8'h84);
    chk("brc_no_bcr", bcr, 1'b0);
    chk("brc_no_ecr", ecr, 1'b0);
    chk("brc_bcid", bcid, 12'd3);
    tick();
    chk("brc_stb_off", brc_stb, 1'b0);

    // Reset during ACK
    put_word(16'h4000);
    chk("mid_clr", bus_if.clr_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_clr", bus_if.clr_valid, 1'b0);
    chk("mid_rst_l1a", l1a, 1'b0);
    chk("mid_rst_bcid", bcid, 12'd0);
    chk("mid_rst_evid", evid, 24'd0);
    chk("mid_rst_err", err_cnt, 8'd0);
    chk("mid_rst_ovf", fifo_ovf, 1'b0);
    chk("mid_rst_tvalid", bus_if.trig_valid, 1'b0);
    chk("mid_rst_brc_cmd", brc_cmd, 8'h00);
    rst = 1'b0;
    tick();
    chk("post_rst_clr", bus_if.clr_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
